// File: rtl/mem_stage_lsu_if.sv
// Bundle between the MEM-stage LSU, the EX/MEM request side, writeback and datamem.
// The LSU uses the slave modport; the pipeline/datamem side uses master.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 8,
  parameter int RD_W   = 4
);
  logic              req_valid;
  logic              req_we;
  logic              req_byte;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [RD_W-1:0]   req_rd;
  logic              req_ready;
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [RD_W-1:0]   wb_rd;
  logic              align_err;
  logic [ADDR_W-1:0] dm_raddr;
  logic [ADDR_W-1:0] dm_waddr;
  logic [31:0]       dm_wdata;
  logic              dm_wea;
  logic [31:0]       dm_dout;

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, req_rd, dm_dout,
    output req_ready, wb_valid, wb_data, wb_rd, align_err,
           dm_raddr, dm_waddr, dm_wdata, dm_wea
  );

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, req_rd, dm_dout,
    input  req_ready, wb_valid, wb_data, wb_rd, align_err,
           dm_raddr, dm_waddr, dm_wdata, dm_wea
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: word/byte loads and stores against a 1-cycle
// synchronous-read datamem; byte stores are done as read-modify-write.
module mem_stage_lsu #(
  parameter int ADDR_W = 8,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_lsu_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_MERGE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic              byte_q, byte_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              align_q, align_d;

  logic [ADDR_W-1:0] req_idx;
  logic [4:0]        lane_sh;
  logic [7:0]        lane_byte;
  logic [31:0]       merged;
  logic              unused_addr_hi;

  assign req_idx        = bus.req_addr[ADDR_W+1:2];
  assign lane_sh        = {lane_q, 3'b000};
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  // Lane extract for byte loads and lane replace for byte-store merge.
  always_comb begin
    lane_byte          = bus.dm_dout[lane_sh +: 8];
    merged             = bus.dm_dout;
    merged[lane_sh +: 8] = wbyte_q;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    rd_d         = rd_q;
    wbyte_d      = wbyte_q;
    byte_d       = byte_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    align_d      = 1'b0;
    bus.req_ready = 1'b0;
    bus.dm_raddr  = idx_q;
    bus.dm_waddr  = idx_q;
    bus.dm_wdata  = merged;
    bus.dm_wea    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.dm_raddr  = req_idx;
        bus.dm_waddr  = req_idx;
        bus.dm_wdata  = bus.req_wdata;
        if (bus.req_valid) begin
          idx_d   = req_idx;
          lane_d  = bus.req_addr[1:0];
          rd_d    = bus.req_rd;
          wbyte_d = bus.req_wdata[7:0];
          byte_d  = bus.req_byte;
          align_d = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);
          if (bus.req_we && !bus.req_byte) bus.dm_wea = 1'b1;
          else if (bus.req_we)             state_d = ST_MERGE;
          else                             state_d = LD_WAIT;
        end
      end
      LD_WAIT: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = byte_q ? {24'b0, lane_byte} : bus.dm_dout;
        state_d    = IDLE;
      end
      ST_MERGE: begin
        bus.dm_wea = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must never let a half-finished sequence reach the memory.
    if (rst) bus.dm_wea = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lane_q     <= '0;
      rd_q       <= '0;
      wbyte_q    <= '0;
      byte_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      align_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      rd_q       <= rd_d;
      wbyte_q    <= wbyte_d;
      byte_q     <= byte_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      align_q    <= align_d;
    end
  end

  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.align_err = align_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases then random traffic, checked against a
// word-array reference memory with per-cycle writeback/align monitoring.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.ADDR_W(8), .RD_W(4)) bus ();
  mem_stage_lsu #(.ADDR_W(8), .RD_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rd;
    int          due;
  } wb_exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          align_due = -10;
  int          occ_prev = 1;
  wb_exp_t     wbq[$];
  logic [31:0] ref_mem [256];
  logic [31:0] dmem [256];
  bit          mem_init = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // datamem stand-in: 1-cycle synchronous read, write on wea
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
      mem_init = 1'b1;
    end
    bus.dm_dout <= dmem[bus.dm_raddr];
    if (bus.dm_wea) dmem[bus.dm_waddr] = bus.dm_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Every cycle: align_err and wb_valid must pulse exactly when the model says.
  always @(posedge clk) begin
    cyc++;
    #1;
    chk("align_err", 32'(bus.align_err), 32'(cyc == align_due));
    if (wbq.size() > 0 && wbq[0].due == cyc) begin
      chk("wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("wb_data", bus.wb_data, wbq[0].data);
      chk("wb_rd", 32'(bus.wb_rd), 32'(wbq[0].rd));
      void'(wbq.pop_front());
    end else begin
      chk("wb_valid_quiet", 32'(bus.wb_valid), 32'd0);
    end
  end

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
    if (n > 0) occ_prev = 1;
  endtask

  task automatic issue(input bit we, input bit byt, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] rd, input bit rst_merge);
    int          waited;
    int          idx;
    int          sh;
    logic [31:0] w, old, expw;
    waited = 0;
    idx = int'(addr[9:2]);
    sh  = 8 * int'(addr[1:0]);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_byte  = byt;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_rd    = rd;
    forever begin
      #1;
      waited++;
      if (bus.req_ready || waited > 8) break;
      @(posedge clk); #2;
    end
    chk("accept_wait", waited, occ_prev);
    if (!bus.req_ready) begin
      chk("req_ready", 32'(bus.req_ready), 32'd1);
      return;
    end
    w = ref_mem[idx];
    if (we && !byt) begin
      chk("st_wea", 32'(bus.dm_wea), 32'd1);
      chk("st_waddr", 32'(bus.dm_waddr), 32'(idx));
      chk("st_wdata", bus.dm_wdata, wd);
      ref_mem[idx] = wd;
      occ_prev = 1;
    end else begin
      chk("accept_wea", 32'(bus.dm_wea), 32'd0);
      chk("accept_raddr", 32'(bus.dm_raddr), 32'(idx));
      occ_prev = 2;
    end
    if (!byt && addr[1:0] != 2'b00) align_due = cyc + 1;
    if (!we) wbq.push_back('{data: byt ? ((w >> sh) & 32'hFF) : w, rd: rd, due: cyc + 2});
    if (we && byt) begin
      old  = w;
      expw = (w & ~(32'hFF << sh)) | ({24'b0, wd[7:0]} << sh);
      ref_mem[idx] = expw;
    end
    @(posedge clk); #2;
    if (we && byt) begin
      if (rst_merge) begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        chk("wea_in_reset", 32'(bus.dm_wea), 32'd0);
        ref_mem[idx] = old;
      end else begin
        #1;
        chk("merge_wea", 32'(bus.dm_wea), 32'd1);
        chk("merge_waddr", 32'(bus.dm_waddr), 32'(idx));
        chk("merge_wdata", bus.dm_wdata, expw);
      end
    end
  endtask

  // Standalone load tail: busy one cycle, then result visible and ready again.
  task automatic after_load();
    bus.req_valid = 1'b0;
    #1;
    chk("ld_busy", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #2;
    chk("ld_ready_again", 32'(bus.req_ready), 32'd1);
    occ_prev = 1;
  endtask

  initial begin
    logic [31:0] a, r;
    int          op, word, lane;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 32'h0000_0010;
    bus.req_wdata = 32'h0BAD_0BAD;
    bus.req_rd    = 4'd0;

    // reset state, with a store held on the bus
    repeat (3) @(posedge clk);
    #3;
    chk("rst_wea", 32'(bus.dm_wea), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_align", 32'(bus.align_err), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #2;
    occ_prev = 1;

    // store then load, same word
    issue(1, 0, 32'h10, 32'hDEAD_BEEF, 4'd0, 0);
    issue(0, 0, 32'h10, 32'h0, 4'd3, 0);
    after_load();
    chk("t1_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("t1_rd", 32'(bus.wb_rd), 32'd3);

    // byte store merge
    issue(1, 0, 32'h20, 32'h1122_3344, 4'd0, 0);
    issue(1, 1, 32'h22, 32'h0000_00AA, 4'd0, 0);
    issue(0, 0, 32'h20, 32'h0, 4'd5, 0);
    after_load();
    chk("t2_merge", bus.wb_data, 32'h11AA_3344);

    // byte loads
    issue(0, 1, 32'h23, 32'h0, 4'd6, 0);
    after_load();
    chk("t3_ldrb23", bus.wb_data, 32'h0000_0011);
    issue(0, 1, 32'h20, 32'h0, 4'd6, 0);
    after_load();
    chk("t3_ldrb20", bus.wb_data, 32'h0000_0044);

    // misaligned word load, address wrap
    issue(0, 0, 32'h16, 32'h0, 4'd7, 0);
    after_load();
    chk("t4_misaligned", bus.wb_data, init_word(5));
    issue(1, 0, 32'h7FC, 32'hCAFE_F00D, 4'd0, 0);
    issue(0, 0, 32'h3FC, 32'h0, 4'd8, 0);
    after_load();
    chk("t4_wrap", bus.wb_data, 32'hCAFE_F00D);

    // reset during the merge cycle
    issue(1, 1, 32'h31, 32'h0000_0055, 4'd0, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("t5_ready", 32'(bus.req_ready), 32'd1);
    chk("t5_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("t5_wb_data", bus.wb_data, 32'd0);
    occ_prev = 1;
    issue(0, 0, 32'h30, 32'h0, 4'd9, 0);
    after_load();
    chk("t5_unchanged", bus.wb_data, init_word(12));

    // back-to-back mix with req_valid held
    issue(1, 0, 32'h40, $urandom, 4'd0, 0);
    issue(1, 0, 32'h44, $urandom, 4'd0, 0);
    issue(0, 0, 32'h40, 32'h0, 4'd1, 0);
    issue(1, 1, 32'h41, $urandom, 4'd0, 0);
    issue(0, 1, 32'h41, 32'h0, 4'd2, 0);
    after_load();

    // random traffic over a small window of words so accesses collide
    for (int n = 0; n < 80; n++) begin
      op   = int'($urandom_range(0, 3));
      word = int'($urandom_range(0, 15));
      lane = int'($urandom_range(0, 3));
      if (op < 2 && $urandom_range(0, 4) != 0) lane = 0;
      r = $urandom;
      a = ($urandom & 32'hFFFF_FC00) | (32'(word) << 2) | 32'(lane);
      issue(op[0], op[1], a, r, 4'($urandom), 0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(4);
    chk("wbq_drained", 32'(wbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
